// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter (start, LSB-first data, stop).
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_arbiter #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 br_tick_i,
    input  logic                 req0_i,
    input  logic [DATA_BITS-1:0] data0_i,
    input  logic                 req1_i,
    input  logic [DATA_BITS-1:0] data1_i,
    output logic                 gnt0_o,
    output logic                 gnt1_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [CW-1:0]          cnt_q;
    logic                   last_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   gnt0_q;
    logic                   gnt1_q;
`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`endif

    logic                   gnt0_d;
    logic                   gnt1_d;
    logic [DATA_BITS-1:0]   win_data_d;

    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        gnt1_d     = req1_i & (~req0_i | ~last_q);
        gnt0_d     = req0_i & ~gnt1_d;
        win_data_d = gnt1_d ? data1_i : data0_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        shift_q <= win_data_d;
                        gnt0_q  <= gnt0_d;
                        gnt1_q  <= gnt1_d;
                        last_q  <= gnt1_d;
                        busy_q  <= 1'b1;
                        state_q <= SYNC;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^win_data_d;
`endif
                    end
                end
                SYNC: begin
                    if (br_tick_i) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (br_tick_i) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (br_tick_i) begin
                        if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (br_tick_i) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (br_tick_i) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int BITP = 20;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic       br_tick;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, tx, tx_busy, tx_done;

    int n_chk  = 0;
    int n_fail = 0;
    int n_gnt0 = 0;
    int n_gnt1 = 0;
    int n_done = 0;
    int tick_ctr;
    int last_m;

    uart_tx_arbiter #(.DATA_BITS(8)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .br_tick_i (br_tick),
        .req0_i    (req0),
        .data0_i   (data0),
        .req1_i    (req1),
        .data1_i   (data1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .tx_o      (tx),
        .tx_busy_o (tx_busy),
        .tx_done_o (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // baud strobe: one clk wide, every BITP clocks, random initial phase
    initial begin
        br_tick  = 1'b0;
        tick_ctr = $urandom_range(0, BITP - 1);
        forever begin
            @(negedge clk);
            br_tick  = (tick_ctr == 0);
            tick_ctr = (tick_ctr + 1) % BITP;
        end
    end

    always @(posedge clk) begin
        if (gnt0 === 1'b1) n_gnt0++;
        if (gnt1 === 1'b1) n_gnt1++;
        if (tx_done === 1'b1) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic r0, input logic r1);
        if (r0 && r1) return (last_m == 0) ? 1 : 0;
        else if (r0)  return 0;
        else          return 1;
    endfunction

    // Waits for a grant, then checks the whole serial frame bit by bit.
    // after: 0 nothing, 1 re-raise winner's req at tx_done, 2 drop both reqs at tx_done
    task automatic do_frame(input int who, input logic [7:0] d, input bit drop,
                            input int after, input int exp_lat, output int waited);
        logic [10:0] bits;
        int lat, bad;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        waited = 0;
        while (!(gnt0 === 1'b1 || gnt1 === 1'b1) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("gnt_seen", 32'(gnt0 | gnt1), 1);
        chk("gnt0_val", 32'(gnt0), 32'(who == 0));
        chk("gnt1_val", 32'(gnt1), 32'(who == 1));
        last_m = who;
        if (drop) begin
            if (who == 0) req0 = 1'b0;
            else          req1 = 1'b0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("gnt_pulse", 32'(gnt0 | gnt1), 0);
        end while (tx !== 1'b0 && lat < 40);
        if (exp_lat > 0) chk("sync_lat", lat, exp_lat);
        else             chk("sync_lat_range", 32'(lat >= 1 && lat <= BITP), 1);
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int c = 0; c < BITP; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (tx !== bits[b] || tx_busy !== 1'b1 || tx_done !== 1'b0) bad++;
            end
            chk($sformatf("frame_bit%0d", b), bad, 0);
        end
        @(negedge clk);
        chk("tx_done", 32'(tx_done), 1);
        chk("busy_end", 32'(tx_busy), 0);
        if (after == 1) begin
            if (who == 0) req0 = 1'b1;
            else          req1 = 1'b1;
        end else if (after == 2) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 32'(tx_done), 0);
        chk("tx_idle", 32'(tx), 1);
    endtask

    initial begin
        int w, who, g0, g1, d0, pat, i;
        logic [7:0] rd;
        reset  = 1'b1;
        req0   = 1'b0;
        req1   = 1'b0;
        data0  = '0;
        data1  = '0;
        last_m = 1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single requester, 0xA5
        data0 = 8'hA5;
        req0  = 1'b1;
        do_frame(winner(1'b1, 1'b0), 8'hA5, 1'b1, 0, -1, w);
        repeat (3) @(negedge clk);

        // fresh reset so requester 0 wins the first tie
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        last_m = 1;
        @(negedge clk);

        // simultaneous requests, re-raised after each frame
        data0 = 8'h11;
        data1 = 8'h22;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            who = winner(1'b1, 1'b1);
            chk("rr_order", who, k % 2);
            do_frame(who, (who == 1) ? 8'h22 : 8'h11, 1'b1, (k < 3) ? 1 : 2, -1, w);
        end
        repeat (4) @(negedge clk);

        // requester 1 held continuously for three frames
        g0    = n_gnt0;
        g1    = n_gnt1;
        data1 = 8'h5A;
        req1  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_frame(winner(1'b0, 1'b1), 8'h5A, k == 2, 0, -1, w);
            if (k > 0) chk("regrant_gap", w, 0);
        end
        chk("gnt0_never", n_gnt0 - g0, 0);
        chk("gnt1_count", n_gnt1 - g1, 3);
        repeat (5) @(negedge clk);

        // request lands so the grant edge coincides with br_tick
        @(posedge clk iff br_tick);
        repeat (BITP) @(negedge clk);
        #1;
        rd    = 8'($urandom);
        data0 = rd;
        req0  = 1'b1;
        do_frame(winner(1'b1, 1'b0), rd, 1'b1, 0, BITP, w);

        // odd-weight payload (parity bit 1 when enabled)
        data0 = 8'h07;
        req0  = 1'b1;
        do_frame(winner(1'b1, 1'b0), 8'h07, 1'b1, 0, -1, w);

        // randomized request patterns and payloads
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            pat   = $urandom_range(1, 3);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            req0  = pat[0];
            req1  = pat[1];
            who   = winner(req0, req1);
            do_frame(who, (who == 1) ? data1 : data0, 1'b1, 2, -1, w);
        end
        repeat (3) @(negedge clk);

        // reset in the middle of data bit 3 of 0xFF, req0 kept high
        data0 = 8'hFF;
        req0  = 1'b1;
        for (i = 0; i < 60 && gnt0 !== 1'b1; i++) @(negedge clk);
        chk("abort_gnt0", 32'(gnt0), 1);
        for (i = 0; i < 40 && tx !== 1'b0; i++) @(negedge clk);
        chk("abort_start", 32'(tx), 0);
        repeat (4 * BITP + 5) @(negedge clk);
        chk("abort_pre_busy", 32'(tx_busy), 1);
        d0 = n_done;
        #1;
        reset = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 1);
        chk("abort_busy", 32'(tx_busy), 0);
        chk("abort_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        last_m = 1;
        do_frame(winner(1'b1, 1'b0), 8'hFF, 1'b1, 0, -1, w);
        chk("abort_regrant", w, 1);
        chk("abort_no_done", n_done - d0, 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
